mmio_uart: RTL
==============

// Module: mmio_uart
// PURPOSE
//  Memory-mapped UART slave on the CPU data bus (Dw*). Consumes address, byte-enables and write data from the datapath.
//  Returns read data combinationally, so the uniciclo datapath completes a load in the same cycle.
//  TX path: FIFO feeding an 8N1 serializer. RX path is optional.
// PARAMETERS
//  BASE_ADDR    32'hFF200110  word-aligned base; decodes 4 words (BASE..BASE+12), iAddress[3:2] selects register
//  FIFO_DEPTH   8             TX FIFO entries, power of 2, >=2
//  DEFAULT_DIV  16'd434       reset value of DIV (clocks per bit)
// PORTS
//  iCLK          in   1   system clock (CPU clock domain)
//  iRST          in   1   asynchronous, active-low reset
//  iReadEnable   in   1   DwReadEnable
//  iWriteEnable  in   1   DwWriteEnable
//  iByteEnable   in   4   DwByteEnable
//  iAddress      in   32  DwAddress
//  iWriteData    in   32  DwWriteData
//  oReadData     out  32  register read data; 0 when not selected
//  oHit          out  1   iAddress within BASE_ADDR..BASE_ADDR+15; used by the bus read mux
//  oTX           out  1   serial out, idle high
//  iRX           in   1   serial in; present only with MMIO_UART_RX_EN
// BEHAVIOUR
//  Reset: oTX=1, FIFO empty, FSM IDLE, DIV=DEFAULT_DIV, all flags 0. oReadData/oHit are combinational.
//  Registers (offset, access):
//   +0  DATA    W: push iWriteData[7:0], only if iByteEnable[0]. R: rx byte in [7:0], zero-extended.
//   +4  STATUS  R: b0 tx_full, b1 tx_empty, b2 tx_busy (FSM!=IDLE), b3 rx_valid, b4 rx_overrun, b5 rx_frame_err, b6 tx_drop.
//               W1C on b4..b6, honours byte-enable 0. Other bits read-only.
//   +8  DIV     R/W [15:0]; written when iByteEnable[1:0]==2'b11. Value 0 acts as 1.
//   +12 reserved; reads 0, writes ignored.
//  Bus access: writes take effect at the posedge where iWriteEnable & oHit. Reads are combinational.
//   Read side-effects (DATA pop) occur at the posedge where iReadEnable & oHit.
//  FIFO push when full: rejected; tx_drop set. Full is sampled before the edge, so a same-edge FSM pop does not admit the push.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//   IDLE: pops FIFO when non-empty and latches the active DIV for the whole frame.
//   Each state bit lasts exactly DIV clocks (baud counter DIV-1 down to 0).
//   Push into an empty FIFO: START begins 1 clock later (FIFO registered). oTX goes low on the edge entering START.
//   Frames are back-to-back: STOP -> START with no idle cycle when the FIFO is non-empty at the end of STOP.
//  A DIV write mid-frame affects the next frame only.
//  Reset mid-frame: oTX returns to 1 immediately (async). FIFO contents are lost.
// CONFIGURATION
//  MMIO_UART_RX_EN defined:
//   - iRX passes through a 2-flop synchroniser.
//   - Falling edge starts a frame; start bit re-checked at DIV/2.
//   - 8 data bits and the stop bit sampled at their bit centres.
//   - Byte stored in a 1-deep holding register; rx_valid set.
//   - Stop bit = 0 sets rx_frame_err; the byte is still stored.
//   - New byte while rx_valid: rx_overrun set, old byte kept.
//   - DATA read clears rx_valid. A same-edge byte arrival wins: rx_valid stays 1, the new byte is stored.
//  Undefined: no iRX port; DATA reads 0; status b3..b5 tied 0; no RX logic.
// STRUCTURE
//  Parametros.v constants:
//   - UART_OFS_DATA/STATUS/DIV
//   - UART_ST_* bit indices
//   - UART_ST_IDLE/START/DATA/STOP FSM encodings
//  Sub-module mmio_uart_fifo (DEPTH, WIDTH=8):
//   - push, pop, full, empty, dout
//   - pointers one bit wider than log2(DEPTH) for full/empty
//  Top holds decode, registers, TX FSM and optional RX FSM.
// TESTING
//  1. DIV=4; store byte 0x55 to BASE.
//     -> oTX low for 4 clk from clk+1, then 1,0,1,0,1,0,1,0 (4 clk each), stop high 4 clk; tx_busy ends at 40 clk.
//  2. DIV=4; 9 stores of 0x00..0x08 in 9 clocks, FSM stalled in frame 0.
//     -> 9th store accepted (one entry already popped). 10th store -> tx_drop=1.
//     -> Frames emitted back-to-back, byte order preserved.
//  3. Write STATUS 0x40 -> tx_drop clears. Write DIV with iByteEnable=4'b0001 -> DIV unchanged.
//  4. Load from BASE+12 -> 0 and oHit=1. Load from BASE+16 -> oHit=0, oReadData=0.
//  5. Drop iRST during frame DATA bit 3.
//     -> oTX=1 combinationally, STATUS reads 0x02 after release.
//     -> DIV=434, the next store starts cleanly.
//  6. (RX_EN) DIV=8; loop oTX->iRX and send 0xA3.
//     -> rx_valid=1, DATA=0xA3.
//     -> Second byte sent without reading: rx_overrun=1, DATA still 0xA3.
//     -> Stop bit forced 0: rx_frame_err=1.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART: register offsets,
// STATUS bit positions, FSM encodings and the baud divisor helper.
package mmio_uart_pkg;

  // Word index within the 16-byte window (address bits [3:2]).
  localparam logic [1:0] UART_OFS_DATA   = 2'd0;
  localparam logic [1:0] UART_OFS_STATUS = 2'd1;
  localparam logic [1:0] UART_OFS_DIV    = 2'd2;

  localparam int UART_ST_TX_FULL      = 0;
  localparam int UART_ST_TX_EMPTY     = 1;
  localparam int UART_ST_TX_BUSY      = 2;
  localparam int UART_ST_RX_VALID     = 3;
  localparam int UART_ST_RX_OVERRUN   = 4;
  localparam int UART_ST_RX_FRAME_ERR = 5;
  localparam int UART_ST_TX_DROP      = 6;

  typedef enum logic [1:0] {
    UART_ST_IDLE  = 2'd0,
    UART_ST_START = 2'd1,
    UART_ST_DATA  = 2'd2,
    UART_ST_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A programmed divisor of 0 behaves as 1 clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_fifo.sv
// Synchronous FIFO for the UART TX path; pointers carry one extra wrap bit
// so full and empty are distinguished without a counter.
module mmio_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART slave for the single-cycle CPU data bus.
// Optional receiver is built when MMIO_UART_RX_EN is defined.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFF200110,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  output logic        oTX
`ifdef MMIO_UART_RX_EN
  ,
  input  logic        iRX
`endif
);

  logic [31:0] offset;
  logic [1:0]  sel;
  logic        hit;
  logic        wr;
  logic        push_req;
  logic        w1c;

  logic [15:0] div_reg;
  logic [15:0] div_eff;
  logic        tx_drop;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  tx_state_t   tx_state;
  logic        tx_line;
  logic [15:0] tx_cnt;
  logic [15:0] tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy;

  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_frame_err;
  logic [7:0]  rx_data;
  logic [6:0]  status;
  logic        unused_bits;

  // Subtracting the base keeps decode correct even for a non 16-byte-aligned base.
  assign offset   = iAddress - BASE_ADDR;
  assign hit      = (offset[31:4] == 28'd0);
  assign sel      = offset[3:2];
  assign oHit     = hit;
  assign wr       = iWriteEnable && hit;
  assign push_req = wr && (sel == UART_OFS_DATA) && iByteEnable[0];
  assign w1c      = wr && (sel == UART_OFS_STATUS) && iByteEnable[0];
  assign div_eff  = eff_div(div_reg);

  assign fifo_push = push_req && !fifo_full;
  assign fifo_pop  = !fifo_empty &&
                     ((tx_state == UART_ST_IDLE) ||
                      ((tx_state == UART_ST_STOP) && (tx_cnt == 16'd0)));
  assign tx_busy   = (tx_state != UART_ST_IDLE);
  assign oTX       = tx_line;

  mmio_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (iWriteData[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      div_reg <= DEFAULT_DIV;
      tx_drop <= 1'b0;
    end else begin
      if (wr && (sel == UART_OFS_DIV) && (iByteEnable[1:0] == 2'b11))
        div_reg <= iWriteData[15:0];
      if (push_req && fifo_full)
        tx_drop <= 1'b1;
      else if (w1c && iWriteData[UART_ST_TX_DROP])
        tx_drop <= 1'b0;
    end
  end

  // TX serializer; the divisor is captured per frame so DIV writes land on the next frame.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      tx_state <= UART_ST_IDLE;
      tx_line  <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd1;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      case (tx_state)
        UART_ST_IDLE: begin
          if (fifo_pop) begin
            tx_state <= UART_ST_START;
            tx_line  <= 1'b0;
            tx_shift <= fifo_dout;
            tx_div   <= div_eff;
            tx_cnt   <= div_eff - 16'd1;
          end
        end
        UART_ST_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= UART_ST_DATA;
            tx_line  <= tx_shift[0];
            tx_bit   <= 3'd0;
            tx_cnt   <= tx_div - 16'd1;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        UART_ST_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= tx_div - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= UART_ST_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_line  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        UART_ST_STOP: begin
          if (tx_cnt == 16'd0) begin
            if (fifo_pop) begin
              tx_state <= UART_ST_START;
              tx_line  <= 1'b0;
              tx_shift <= fifo_dout;
              tx_div   <= div_eff;
              tx_cnt   <= div_eff - 16'd1;
            end else begin
              tx_state <= UART_ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

`ifdef MMIO_UART_RX_EN
  rx_state_t   rx_state;
  logic        rx_sync1;
  logic        rx_sync2;
  logic        rx_prev;
  logic [15:0] rx_cnt;
  logic [15:0] rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_pop;

  assign rx_pop = iReadEnable && hit && (sel == UART_OFS_DATA);

  // Arrival is evaluated after the pop so a same-edge byte keeps rx_valid set.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rx_sync1     <= 1'b1;
      rx_sync2     <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= 16'd0;
      rx_div       <= 16'd1;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'd0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync1 <= iRX;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      if (rx_pop) rx_valid <= 1'b0;
      if (w1c && iWriteData[UART_ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
      if (w1c && iWriteData[UART_ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync2 && rx_prev) begin
            rx_state <= RX_START;
            rx_div   <= div_eff;
            rx_cnt   <= {1'b0, div_eff[15:1]};
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (!rx_sync2) begin
              rx_state <= RX_DATA;
              rx_bit   <= 3'd0;
              rx_cnt   <= rx_div - 16'd1;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_sync2, rx_shift[7:1]};
            rx_cnt   <= rx_div - 16'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= RX_IDLE;
            if (!rx_sync2) rx_frame_err <= 1'b1;
            if (rx_valid && !rx_pop) begin
              rx_overrun <= 1'b1;
            end else begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  assign unused_bits = ^{iWriteData[31:16], iByteEnable[3:2], offset[1:0]};
`else
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_data      = 8'd0;
  assign unused_bits  = ^{iWriteData[31:16], iWriteData[5:4], iByteEnable[3:2],
                          offset[1:0], iReadEnable};
`endif

  always_comb begin
    status                       = '0;
    status[UART_ST_TX_FULL]      = fifo_full;
    status[UART_ST_TX_EMPTY]     = fifo_empty;
    status[UART_ST_TX_BUSY]      = tx_busy;
    status[UART_ST_RX_VALID]     = rx_valid;
    status[UART_ST_RX_OVERRUN]   = rx_overrun;
    status[UART_ST_RX_FRAME_ERR] = rx_frame_err;
    status[UART_ST_TX_DROP]      = tx_drop;
  end

  always_comb begin
    oReadData = 32'd0;
    if (hit) begin
      case (sel)
        UART_OFS_DATA:   oReadData = {24'd0, rx_data};
        UART_OFS_STATUS: oReadData = {25'd0, status};
        UART_OFS_DIV:    oReadData = {16'd0, div_reg};
        default:         oReadData = 32'd0;
      endcase
    end
  end

endmodule
